// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// reset/enable polarities and clear-engine state encodings.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] ZeroWord = 32'h0000_0000;
  localparam logic RstEnable   = 1'b0;
  localparam logic ReadEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequenced clear engine: once started, walks every entry address one per
// cycle and raises a busy flag for exactly 2**ADDR_W cycles.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_strobe,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_r;
  clr_state_e        state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;

  // state and address counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_r <= CLR_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // next state: requests are ignored while clearing; exit after the last entry
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      CLR_IDLE: begin
        cnt_s = '0;
        if (clr_req) begin
          state_s = CLR_CLEAR;
        end else begin
          state_s = CLR_IDLE;
        end
      end
      CLR_CLEAR: begin
        cnt_s = cnt_r + ADDR_W'(1);
        if (cnt_r == {ADDR_W{1'b1}}) begin
          state_s = CLR_IDLE;
        end else begin
          state_s = CLR_CLEAR;
        end
      end
      default: begin
        state_s = CLR_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  assign clr_busy   = (state_r == CLR_CLEAR);
  assign clr_strobe = (state_r == CLR_CLEAR);
  assign clr_addr   = cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: N reads, M writes (higher port wins), conflict flag,
// sequenced clear. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              clr_busy_s;
  logic              clr_strobe_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              conflict_s;
  logic              wr_conflict_r;
  logic [DATA_W-1:0] rd_s;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy_s),
    .clr_strobe (clr_strobe_s),
    .clr_addr   (clr_addr_s)
  );

  // storage: clear engine owns the array while busy; later ports overwrite earlier ones
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_r[e] <= '0;
      end
    end else if (clr_strobe_s) begin
      mem_r[clr_addr_s] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if ((we[k] == WriteEnable) && !is_zero_reg(waddr[k*ADDR_W +: ADDR_W])) begin
          mem_r[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // any pair of enabled ports on the same real address, data ignored
  always_comb begin
    conflict_s = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        conflict_s = conflict_s | (we[a] & we[b] &
                     (waddr[a*ADDR_W +: ADDR_W] == waddr[b*ADDR_W +: ADDR_W]) &
                     !is_zero_reg(waddr[a*ADDR_W +: ADDR_W]));
      end
    end
  end

  // conflict flag register, suppressed during clear
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_conflict_r <= 1'b0;
    end else begin
      wr_conflict_r <= conflict_s & ~clr_busy_s;
    end
  end

  // combinational read ports with priority-ordered zeroing
  always_comb begin
    rdata = '0;
    rd_s  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst == RstEnable) begin
        rd_s = '0;
      end else if (clr_busy_s) begin
        rd_s = '0;
      end else if (re[i] != ReadEnable) begin
        rd_s = '0;
      end else if (is_zero_reg(raddr[i*ADDR_W +: ADDR_W])) begin
        rd_s = '0;
      end else begin
        rd_s = mem_r[raddr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NUM_WR; k++) begin
          rd_s = ((we[k] == WriteEnable) &&
                  (waddr[k*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])) ?
                 wdata[k*DATA_W +: DATA_W] : rd_s;
        end
`endif
      end
      rdata[i*DATA_W +: DATA_W] = rd_s;
    end
  end

  assign clr_busy    = clr_busy_s;
  assign wr_conflict = wr_conflict_r;

endmodule
